pipelined_add_sub_flags: RTL
============================

Name: pipelined_add_sub_flags

Overview:
- Parametrised, pipelined adder/subtractor with ALU status flags; successor to the single-cycle combinational full adder with flags.
- Carry chain split into CHUNK-bit slices, one slice per pipeline stage, so wide datapaths close timing. One operation accepted per cycle.
- Valid/ready handshake on both sides. Sits between the ALU operand latch and the writeback/flag register.

Parameters:
- L, 16, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage; 1 <= CHUNK <= L.
- STAGES, L/CHUNK (derived localparam), pipeline depth.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- InValid  input  1  operand pair and Sub are valid this cycle.
- InReady  output  1  block accepts the input this cycle.
- X  input  L  operand A (two's complement or unsigned).
- Y  input  L  operand B.
- Sub  input  1  0: S = X+Y; 1: S = X-Y.
- OutValid  output  1  result and flags are valid.
- OutReady  input  1  consumer takes the result this cycle.
- S  output  L  result, modulo 2^L.
- Overflow  output  1  signed overflow.
- Carry  output  1  carry-out of bit L-1.
- Zero  output  1  S == 0.
- Negative  output  1  S[L-1].

Behaviour:
- Arithmetic: computes X + (Sub ? ~Y : Y) + Sub.
  - Carry is the raw carry-out of that sum. For Sub, Carry=1 means no borrow (X >= Y unsigned).
  - Overflow = carry into bit L-1 XOR carry out of bit L-1.
- Stage i (1..STAGES) computes chunk i-1 (bits [i*CHUNK-1:(i-1)*CHUNK]) using the carry registered by stage i-1. Stage 1 uses Sub as carry-in.
- Still-unprocessed operand bits and the Sub-inverted Y travel with each stage. Finished result chunks are carried forward.
- Zero accumulates per stage as the AND of "chunk == 0" terms.
- Global advance signal: Adv = ~OutValid | OutReady. InReady = Adv, combinational, with no dependency on InValid.
- Every stage register, including its valid bit, loads only when Adv=1. When Adv=0 all stages hold; bubbles are not collapsed.
- Transfer in when InValid & InReady. Transfer out when OutValid & OutReady.
- Latency: if accepted at edge n and no stall occurs, OutValid=1 with correct S and flags after edge n+STAGES-1. For STAGES=1 the result appears after the accepting edge.
- Throughput: 1 result/cycle while OutReady=1.
- Outputs (S, flags, OutValid) come directly from the final stage register; no combinational path from X/Y to outputs.
- While OutValid=1 and OutReady=0, S and all flags are held stable.
- Reset (Reset=1 at a rising edge):
  - All stage valid bits clear; S, Overflow, Carry, Zero, Negative = 0; OutValid = 0.
  - InReady reads 1 from the following cycle.
  - In-flight operations are discarded. An input presented during the reset cycle is not accepted.
- InValid=0: a bubble enters stage 1 on Adv.

Test Plan:
- L=16, CHUNK=4, Sub=0: X=0x7FFF, Y=0x0001 -> after 4 cycles S=0x8000, Overflow=1, Carry=0, Zero=0, Negative=1.
- Sub=0: X=0xFFFF, Y=0x0001 -> S=0x0000, Carry=1, Zero=1, Overflow=0, Negative=0. Then X=0x8030, Y=0x80E0 -> S=0x0110, Overflow=1, Carry=1.
- Sub=1: X=0x0005, Y=0x0007 -> S=0xFFFE, Carry=0, Negative=1, Overflow=0. Then X=0x8000, Y=0x0001 -> S=0x7FFF, Overflow=1, Carry=1. Then X=Y=0x1234 -> S=0, Zero=1, Carry=1.
- Throughput/backpressure:
  - Stream 8 back-to-back ops with OutReady=1 -> 8 consecutive OutValid cycles, results in order.
  - Drop OutReady for 3 cycles mid-stream -> InReady=0 for those cycles, held output unchanged, no loss or duplication.
- Reset mid-flight: Reset=1 with 3 ops in the pipe -> next cycle OutValid=0, all outputs 0, InReady=1. No stale result emerges in the following 5 cycles.
- Parameter sweep: CHUNK=16 (STAGES=1) and L=32, CHUNK=8 -> 1-cycle and 4-cycle latency respectively. 1000 random ops checked against a reference model X±Y with the flag equations above.

Source files
------------

// File: rtl/pipelined_add_sub_flags.sv
// Pipelined adder/subtractor with ALU status flags. The carry chain is cut into
// CHUNK-bit slices, one slice per stage, so wide datapaths close timing.
module pipelined_add_sub_flags #(
  parameter int L     = 16,
  parameter int CHUNK = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [L-1:0] X,
  input  logic [L-1:0] Y,
  input  logic         Sub,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [L-1:0] S,
  output logic         Overflow,
  output logic         Carry,
  output logic         Zero,
  output logic         Negative
);
  localparam int STAGES = L / CHUNK;

  // Handshake: a transfer happens on any edge where valid and ready are both
  // high. The whole pipe advances together when the output slot is free or
  // being drained; InReady never looks at InValid.
  logic adv;
  logic ovf_q;

  assign adv     = ~OutValid | OutReady;
  assign InReady = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int R = L - k * CHUNK;  // operand bits not yet added
    localparam int W = (k + 1) * CHUNK;  // result bits finished after this stage

    logic           vin;
    logic           cin;
    logic           zin;
    logic [R-1:0]   xin;
    logic [R-1:0]   ybin;
    logic [W-1:0]   sout;
    logic [CHUNK:0] sum;

    logic           vld_q;
    logic           c_q;
    logic           z_q;
    logic [W-1:0]   s_q;

    assign sum = {1'b0, xin[CHUNK-1:0]} + {1'b0, ybin[CHUNK-1:0]} + {{CHUNK{1'b0}}, cin};

    if (k == 0) begin : g_head
      assign vin  = InValid;
      assign xin  = X;
      assign ybin = Sub ? ~Y : Y;
      assign cin  = Sub;
      assign zin  = 1'b1;
      assign sout = sum[CHUNK-1:0];
    end else begin : g_body
      assign vin  = g_stage[k-1].vld_q;
      assign xin  = g_stage[k-1].g_fwd.x_q;
      assign ybin = g_stage[k-1].g_fwd.yb_q;
      assign cin  = g_stage[k-1].c_q;
      assign zin  = g_stage[k-1].z_q;
      assign sout = {sum[CHUNK-1:0], g_stage[k-1].s_q};
    end

    always_ff @(posedge Clk) begin
      if (Reset) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        z_q   <= 1'b0;
        s_q   <= '0;
      end else if (adv) begin
        vld_q <= vin;
        c_q   <= sum[CHUNK];
        z_q   <= zin & (sum[CHUNK-1:0] == '0);
        s_q   <= sout;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [R-CHUNK-1:0] x_q;
      logic [R-CHUNK-1:0] yb_q;

      always_ff @(posedge Clk) begin
        if (Reset) begin
          x_q  <= '0;
          yb_q <= '0;
        end else if (adv) begin
          x_q  <= xin[R-1:CHUNK];
          yb_q <= ybin[R-1:CHUNK];
        end
      end
    end else begin : g_last
      // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= xin[CHUNK-1] ^ ybin[CHUNK-1] ^ sum[CHUNK-1] ^ sum[CHUNK];
        end
      end
    end
  end

  assign OutValid = g_stage[STAGES-1].vld_q;
  assign S        = g_stage[STAGES-1].s_q;
  assign Carry    = g_stage[STAGES-1].c_q;
  assign Zero     = g_stage[STAGES-1].z_q;
  assign Negative = g_stage[STAGES-1].s_q[L-1];
  assign Overflow = ovf_q;

endmodule
